serial_pattern_gen: RTL and testbench

Serial bit-stream transmitter that drives the single-bit sequence-detector input.
- Accepts a parallel word over a valid/ready handshake and shifts it out MSB-first on `x`, one bit per clock.
- Appends a zero-filled gap after each word so a downstream "10" detector returns to its idle state between words.
- Reports `exp_cnt`, the number of "10" occurrences the detector must flag for that word. Benches use it as the scoreboard reference.

---
 rtl/serial_pattern_gen.sv | 131 +++++++++++++
 tb/tb_serial_pattern_gen.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/serial_pattern_gen.sv
// serial_pattern_gen: MSB-first serial word transmitter with zero gap and expected "10" count; optional auto-repeat via SERIAL_PATTERN_GEN_REPEAT_EN
module serial_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int GAP_CYCLES = 2,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             repeat_en,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    exp_cnt
);
    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [3:0]       gap_q, gap_d;
    logic             x_q, x_d, xv_q, xv_d, done_q, done_d;
    logic             ready_q, ready_d, busy_q, busy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             restart;

`ifdef SERIAL_PATTERN_GEN_REPEAT_EN
    assign restart = repeat_en;
`else
    logic unused_repeat_en;
    assign unused_repeat_en = repeat_en;
    assign restart = 1'b0;
`endif

    // The shift register rotates, so after a full pass it holds the word again for a repeat.
    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] w);
        rotl = {w[WIDTH-2:0], w[WIDTH-1]};
    endfunction

    // Interior falling edges plus the one formed by bit 0 against the first gap zero.
    function automatic logic [CW-1:0] count_10(input logic [WIDTH-1:0] w);
        count_10 = CW'(w[0]);
        for (int i = 0; i < WIDTH - 1; i++) count_10 += CW'(w[i+1] & ~w[i]);
    endfunction

    // Next-state and next-output computation; every output is registered from these.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        cnt_d   = cnt_q;
        x_d     = 1'b0;
        xv_d    = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (load_valid) begin
                state_d = SHIFT;
                shift_d = rotl(data_in);
                bit_d   = '0;
                cnt_d   = count_10(data_in);
                x_d     = data_in[WIDTH-1];
                xv_d    = 1'b1;
            end
            SHIFT: if (bit_q == BIT_LAST) begin
                state_d = GAP;
                gap_d   = '0;
                done_d  = GAP_LAST == 4'd0;
            end else begin
                bit_d   = bit_q + BW'(1);
                shift_d = rotl(shift_q);
                x_d     = shift_q[WIDTH-1];
                xv_d    = 1'b1;
            end
            GAP: if (gap_q == GAP_LAST) begin
                state_d = restart ? SHIFT : IDLE;
                shift_d = restart ? rotl(shift_q) : shift_q;
                bit_d   = '0;
                x_d     = restart & shift_q[WIDTH-1];
                xv_d    = restart;
            end else begin
                gap_d  = gap_q + 4'd1;
                done_d = gap_d == GAP_LAST;
            end
            default: state_d = IDLE;
        endcase
        ready_d = state_d == IDLE;
        busy_d  = state_d != IDLE;
    end

    // State and output registers; reset discards any word in flight immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            cnt_q   <= '0;
            x_q     <= 1'b0;
            xv_q    <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            xv_q    <= xv_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign x          = x_q;
    assign x_valid    = xv_q;
    assign done       = done_q;
    assign load_ready = ready_q;
    assign busy       = busy_q;
    assign exp_cnt    = cnt_q;
endmodule

// File: tb/tb_serial_pattern_gen.sv
// tb_serial_pattern_gen: random and directed checks of serial_pattern_gen against a per-cycle expected-output queue
module tb_serial_pattern_gen;
    localparam int W = 8;
    localparam int G = 2;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  din = '0;
    logic          lv = 1'b0;
    logic          rep = 1'b0;
    logic          load_ready, x, x_valid, busy, done;
    logic [CW-1:0] exp_cnt;

    serial_pattern_gen #(.WIDTH(W), .GAP_CYCLES(G)) dut (
        .clk(clk), .rst(rst), .data_in(din), .load_valid(lv), .load_ready(load_ready),
        .repeat_en(rep), .x(x), .x_valid(x_valid), .busy(busy), .done(done), .exp_cnt(exp_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic x; logic xv; logic dn;} beat_t;
    beat_t q[$];
    int    m_cnt = 0;
    int    errors = 0;
    int    checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Count "10" in the transmitted stream: word bits MSB first, then a zero.
    function automatic int ref_cnt(input logic [W-1:0] w);
        logic s[W+1];
        int n = 0;
        for (int i = 0; i < W; i++) s[i] = w[W-1-i];
        s[W] = 1'b0;
        for (int i = 0; i < W; i++) if (s[i] && !s[i+1]) n++;
        return n;
    endfunction

    task automatic push_word(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) q.push_back('{w[W-1-i], 1'b1, 1'b0});
        for (int g = 0; g < G; g++) q.push_back('{1'b0, 1'b0, g == G - 1});
    endtask

    task automatic check_outputs();
        beat_t e = (q.size() != 0) ? q[0] : '0;
        chk("x", x, e.x);
        chk("x_valid", x_valid, e.xv);
        chk("done", done, e.dn);
        chk("busy", busy, q.size() != 0);
        chk("load_ready", load_ready, q.size() == 0);
        chk("exp_cnt", exp_cnt, m_cnt);
    endtask

    task automatic cycle(input logic v, input logic [W-1:0] d, input logic r);
        logic acc, last;
        logic [W-1:0] w;
        @(negedge clk);
        lv = v;
        din = d;
        rep = r;
        acc = v && q.size() == 0;
        last = q.size() == 1 && q[0].dn;
        @(posedge clk);
        if (q.size() != 0) void'(q.pop_front());
        if (acc) begin
            m_cnt = ref_cnt(d);
            push_word(d);
            w = d;
        end
`ifdef SERIAL_PATTERN_GEN_REPEAT_EN
        if (last && r) push_word(dut.shift_q);
`endif
        #1 check_outputs();
    endtask

    task automatic mid_reset();
        #2 rst = 1'b0;
        lv = 1'b0;
        q.delete();
        m_cnt = 0;
        #1 check_outputs();
        chk("rst_x", x, 0);
        chk("rst_ready", load_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, W'($urandom), 1'b0);
    endtask

    initial begin
        #1 rst = 1'b0;
        #1 check_outputs();
        chk("rst_cnt", exp_cnt, 0);
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        cycle(1'b1, 8'b1010_0110, 1'b0);
        chk("cnt_a6", exp_cnt, 3);
        chk("a6_bit0", x, 1);
        idle(W + G + 1);
        cycle(1'b1, 8'hFF, 1'b0);
        chk("cnt_ff", exp_cnt, 1);
        idle(W + G);
        cycle(1'b1, 8'h00, 1'b0);
        chk("cnt_00", exp_cnt, 0);
        idle(W + G);
        cycle(1'b1, 8'hA0, 1'b0);
        for (int i = 0; i < W + G + 1; i++) cycle(1'b1, 8'h55, 1'b0);
        chk("cnt_55", exp_cnt, 4);
        chk("busy_55", busy, 1);
        idle(W + G);
        cycle(1'b1, 8'hC3, 1'b0);
        idle(3);
        mid_reset();
        idle(2);
        cycle(1'b1, 8'h81, 1'b0);
        chk("cnt_81", exp_cnt, 2);
        idle(W + G + 1);
`ifdef SERIAL_PATTERN_GEN_REPEAT_EN
        cycle(1'b1, 8'b1001_0000, 1'b1);
        for (int i = 0; i < 3 * (W + G); i++) cycle(1'b0, 8'h00, 1'b1);
        chk("cnt_90", exp_cnt, 2);
        idle(W + G + 2);
`endif
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) mid_reset();
            else cycle($urandom_range(0, 2) == 0, W'($urandom), 1'($urandom));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
